// File: rtl/fft_sat_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_sat_pkg
//  Description : Shared types and constants for the FFT saturation-stage
//                frame controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_sat_pkg;

  // Frame controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Lanes per array in the default configuration; four arrays feed the stage
  localparam int DEPTH_DEFAULT   = 16;
  localparam int NUM_LANES       = 4 * DEPTH_DEFAULT;

  // Default clip thresholds (inclusive limits are legal, beyond them clips)
  localparam int SAT_MAX_DEFAULT = 4095;
  localparam int SAT_MIN_DEFAULT = -4096;

endpackage
`default_nettype wire

// File: rtl/sat_clip_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_clip_counter
//  Description : Combinational range check of every stage input lane against
//                the clip thresholds, followed by a popcount of the lanes that
//                fall outside the legal range.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_clip_counter
  import fft_sat_pkg::*;
#(
  parameter int WIDTH       = 14,
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int SAT_MAX_VAL = SAT_MAX_DEFAULT,
  parameter int SAT_MIN_VAL = SAT_MIN_DEFAULT,
  parameter int PC_WIDTH    = $clog2(4 * DEPTH + 1)
) (
  input  logic signed [WIDTH-1:0] din_R_add [DEPTH],
  input  logic signed [WIDTH-1:0] din_R_sub [DEPTH],
  input  logic signed [WIDTH-1:0] din_Q_add [DEPTH],
  input  logic signed [WIDTH-1:0] din_Q_sub [DEPTH],
  output logic [PC_WIDTH-1:0]     clip_count
);

  localparam int LANES = 4 * DEPTH;

  logic [LANES-1:0] clip_flag;

  // Signed compare after sign extension to int; the thresholds themselves are legal
  function automatic logic is_clip(input logic signed [WIDTH-1:0] s);
    return (int'(s) > SAT_MAX_VAL) || (int'(s) < SAT_MIN_VAL);
  endfunction

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_lane
      assign clip_flag[i]           = is_clip(din_R_add[i]);
      assign clip_flag[DEPTH + i]   = is_clip(din_R_sub[i]);
      assign clip_flag[2*DEPTH + i] = is_clip(din_Q_add[i]);
      assign clip_flag[3*DEPTH + i] = is_clip(din_Q_sub[i]);
    end
  endgenerate

  // Popcount of the clip flags over all lanes
  always_comb begin
    clip_count = '0;
    for (int i = 0; i < LANES; i++) begin
      clip_count = clip_count + PC_WIDTH'(clip_flag[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fft_sat_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fft_sat_ctrl
//  Description : Frame-level controller for the 16-lane, 4-array saturation
//                stage. Sequences one frame of blocks with valid/ready flow
//                control, drives the stage enable, tracks the block index at
//                the stage output and accumulates per-frame clip counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_sat_ctrl
  import fft_sat_pkg::*;
#(
  parameter int WIDTH          = 14,
  parameter int DEPTH          = DEPTH_DEFAULT,
  parameter int SAT_MAX_VAL    = SAT_MAX_DEFAULT,
  parameter int SAT_MIN_VAL    = SAT_MIN_DEFAULT,
  parameter int BLKS_PER_FRAME = 32,
  parameter int CNT_WIDTH      = 11
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [WIDTH-1:0]           din_R_add [DEPTH],
  input  logic signed [WIDTH-1:0]           din_R_sub [DEPTH],
  input  logic signed [WIDTH-1:0]           din_Q_add [DEPTH],
  input  logic signed [WIDTH-1:0]           din_Q_sub [DEPTH],
  output logic                              sat_en,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(BLKS_PER_FRAME)-1:0] blk_idx,
  output logic                              frame_last,
  output logic                              busy,
  output logic                              done,
  output logic [CNT_WIDTH-1:0]              clip_cnt,
  output logic                              clip_any
);

  localparam int IDX_W    = $clog2(BLKS_PER_FRAME);
  localparam int PC_WIDTH = $clog2(4 * DEPTH + 1);
  localparam int LAST_BLK = BLKS_PER_FRAME - 1;

  state_t               state;
  state_t               state_nxt;
  logic [IDX_W-1:0]     in_cnt;
  logic [CNT_WIDTH-1:0] acc;
  logic [CNT_WIDTH:0]   acc_sum;
  logic [PC_WIDTH-1:0]  blk_clips;
  logic                 accept;
  logic                 last_in;
  logic                 last_out;

  sat_clip_counter #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .SAT_MAX_VAL (SAT_MAX_VAL),
    .SAT_MIN_VAL (SAT_MIN_VAL),
    .PC_WIDTH    (PC_WIDTH)
  ) u_clip (
    .din_R_add  (din_R_add),
    .din_R_sub  (din_R_sub),
    .din_Q_add  (din_Q_add),
    .din_Q_sub  (din_Q_sub),
    .clip_count (blk_clips)
  );

  // A new block may enter whenever the output slot is empty or being drained
  assign in_ready   = (state == RUN) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign sat_en     = accept;
  assign last_in    = (in_cnt == IDX_W'(LAST_BLK));
  assign last_out   = (blk_idx == IDX_W'(LAST_BLK));
  assign frame_last = out_valid && last_out;
  assign clip_any   = (clip_cnt != '0);

  // One extra bit catches overflow so the accumulator can saturate
  assign acc_sum = {1'b0, acc} + {{(CNT_WIDTH + 1 - PC_WIDTH){1'b0}}, blk_clips};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (accept && last_in) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (out_valid && out_ready && last_out) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Input block counter and saturating clip accumulator, both restarted by start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_cnt <= '0;
      acc    <= '0;
    end else if (state == IDLE && start) begin
      in_cnt <= '0;
      acc    <= '0;
    end else if (accept) begin
      in_cnt <= last_in ? '0 : in_cnt + 1'b1;
      acc    <= acc_sum[CNT_WIDTH] ? '1 : acc_sum[CNT_WIDTH-1:0];
    end
  end

  // Output-slot valid and index track the stage register one cycle behind accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      blk_idx   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      blk_idx   <= in_cnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Publish the frame clip count when the last block leaves the stage
  always_ff @(posedge clk) begin
    if (!rst_n)                                   clip_cnt <= '0;
    else if (state == DRAIN && state_nxt == DONE) clip_cnt <= acc;
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_sat_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_sat_ctrl
//  Description : Self-checking bench for fft_sat_ctrl: table of whole-frame
//                clip scenarios, hand-written reset/backpressure/boundary
//                sequences and randomized frames against a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fft_sat_ctrl;

  localparam int WIDTH = 14;
  localparam int DEPTH = 16;
  localparam int BLKS  = 32;
  localparam int CNTW  = 11;
  localparam int IDXW  = 5;
  localparam int LANES = 64;
  localparam int SMAX  = 4095;
  localparam int SMIN  = -4096;
  localparam int CMAX  = 2047;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, sat_en, out_valid, frame_last, busy, done, clip_any;
  logic [IDXW-1:0] blk_idx;
  logic [CNTW-1:0] clip_cnt;
  logic signed [WIDTH-1:0] din_R_add [DEPTH];
  logic signed [WIDTH-1:0] din_R_sub [DEPTH];
  logic signed [WIDTH-1:0] din_Q_add [DEPTH];
  logic signed [WIDTH-1:0] din_Q_sub [DEPTH];
  int lanes [LANES];

  int checks = 0;
  int failures = 0;

  // Frame-level reference model state
  bit m_active = 0, m_ov = 0, m_done = 0;
  int m_cnt = 0, m_idx = 0, m_sum = 0, m_clip = 0;
  int n_out = 0, n_acc = 0, cyc = 0, t_last = 0, t_done = 0;

  fft_sat_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .din_R_add(din_R_add), .din_R_sub(din_R_sub),
    .din_Q_add(din_Q_add), .din_Q_sub(din_Q_sub), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready), .blk_idx(blk_idx),
    .frame_last(frame_last), .busy(busy), .done(done),
    .clip_cnt(clip_cnt), .clip_any(clip_any)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      din_R_add[i] = WIDTH'(lanes[i]);
      din_R_sub[i] = WIDTH'(lanes[DEPTH + i]);
      din_Q_add[i] = WIDTH'(lanes[2*DEPTH + i]);
      din_Q_sub[i] = WIDTH'(lanes[3*DEPTH + i]);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int count_clips();
    int c = 0;
    for (int k = 0; k < LANES; k++)
      if (lanes[k] > SMAX || lanes[k] < SMIN) c++;
    return c;
  endfunction

  function automatic bit exp_in_ready();
    return m_active && (m_cnt < BLKS) && (!m_ov || out_ready);
  endfunction

  task automatic fill_all(input int v);
    for (int k = 0; k < LANES; k++) lanes[k] = v;
  endtask

  // Compare every output with the model mid-cycle
  task automatic check_outputs();
    bit er;
    er = exp_in_ready();
    check("in_ready", in_ready, er);
    check("sat_en", sat_en, er && in_valid);
    check("out_valid", out_valid, m_ov);
    check("blk_idx", blk_idx, m_idx);
    check("frame_last", frame_last, m_ov && m_idx == BLKS - 1);
    check("busy", busy, m_active || m_done);
    check("done", done, m_done);
    check("clip_cnt", clip_cnt, m_clip);
    check("clip_any", clip_any, m_clip != 0);
    if (out_valid && out_ready) n_out++;
    if (sat_en) n_acc++;
    if (frame_last && out_ready) t_last = cyc;
    if (done) t_done = cyc;
  endtask

  // Advance the model by one clock using the inputs presented this cycle
  task automatic model_edge();
    bit acc, fin;
    if (!rst_n) begin
      m_active = 0; m_ov = 0; m_done = 0;
      m_cnt = 0; m_idx = 0; m_sum = 0; m_clip = 0;
      return;
    end
    acc = in_valid && exp_in_ready();
    fin = m_active && m_cnt == BLKS && m_ov && out_ready && m_idx == BLKS - 1;
    if (m_done) m_done = 0;
    else if (!m_active && start) begin
      m_active = 1; m_cnt = 0; m_sum = 0;
    end else if (acc) begin
      m_sum = (m_sum + count_clips() > CMAX) ? CMAX : m_sum + count_clips();
      m_idx = m_cnt;
      m_cnt++;
    end else if (fin) begin
      m_clip = m_sum; m_done = 1; m_active = 0;
    end
    if (acc) m_ov = 1;
    else if (out_ready) m_ov = 0;
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  // Lane contents for the block about to be offered
  // mode 0: first nl lanes of blocks < nb = val; mode 1: random; mode 2: threshold boundary
  task automatic load_block(input int mode, input int val, input int nl, input int nb);
    int r;
    if (!in_valid) begin
      fill_all(8191);
      return;
    end
    for (int k = 0; k < LANES; k++) begin
      case (mode)
        0: lanes[k] = (m_cnt < nb && k < nl) ? val : 0;
        1: begin
          r = int'($urandom_range(0, 15));
          if (r == 0)      lanes[k] = int'($urandom_range(4096, 8191));
          else if (r == 1) lanes[k] = -int'($urandom_range(4097, 8192));
          else if (r == 2) lanes[k] = SMAX;
          else if (r == 3) lanes[k] = SMIN;
          else             lanes[k] = int'($urandom_range(0, 8191)) - 4096;
        end
        default: lanes[k] = 0;
      endcase
    end
    if (mode == 2 && m_cnt == 0) begin
      lanes[0] = 4095; lanes[17] = -4096; lanes[34] = 4096; lanes[51] = -4097;
    end
  endtask

  task automatic run_frame(input int mode, input int val, input int nl, input int nb,
                           input bit rnd, input bit junk_start);
    int guard;
    guard = 0; n_out = 0; n_acc = 0;
    in_valid = 0; out_ready = 1; fill_all(0);
    start = 1;
    step();
    start = 0;
    while (!m_done && guard < 3000) begin
      in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      start     = junk_start ? ($urandom_range(0, 2) == 0) : 1'b0;
      load_block(mode, val, nl, nb);
      step();
      guard++;
    end
    start = 0; in_valid = 0; out_ready = 1;
    if (!m_done) check("frame_timeout", 0, 1);
    step();
    check("frame_outputs", n_out, BLKS);
    check("frame_accepts", n_acc, BLKS);
    check("done_after_last", t_done - t_last, 1);
  endtask

  typedef struct packed {
    int val;
    int nl;
    int nb;
    int exp_clip;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int guard;
    tbl[0] = '{val: 0,     nl: 64, nb: 32, exp_clip: 0};
    tbl[1] = '{val: 4095,  nl: 64, nb: 32, exp_clip: 0};
    tbl[2] = '{val: -4096, nl: 64, nb: 32, exp_clip: 0};
    tbl[3] = '{val: 4096,  nl: 1,  nb: 1,  exp_clip: 1};
    tbl[4] = '{val: -4097, nl: 3,  nb: 2,  exp_clip: 6};
    tbl[5] = '{val: 5000,  nl: 10, nb: 32, exp_clip: 320};
    tbl[6] = '{val: -8192, nl: 64, nb: 31, exp_clip: 1984};
    tbl[7] = '{val: 8191,  nl: 64, nb: 32, exp_clip: 2047};
    tbl[8] = '{val: -8192, nl: 64, nb: 32, exp_clip: 2047};

    fill_all(0);
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_sat_en", sat_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_blk_idx", blk_idx, 0);
    check("rst_frame_last", frame_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_clip_cnt", clip_cnt, 0);
    check("rst_clip_any", clip_any, 0);
    rst_n = 1;
    out_ready = 1;
    repeat (2) step();

    // Whole-frame clip scenarios, streaming at full throughput
    for (int i = 0; i < 9; i++) begin
      run_frame(0, tbl[i].val, tbl[i].nl, tbl[i].nb, 1'b0, 1'b0);
      check("tbl_clip_cnt", clip_cnt, tbl[i].exp_clip);
      check("tbl_clip_any", clip_any, tbl[i].exp_clip != 0);
    end

    // Threshold boundary: only the two out-of-range lanes of block 0 count
    run_frame(2, 0, 0, 0, 1'b0, 1'b0);
    check("boundary_clip_cnt", clip_cnt, 2);

    // Backpressure: stall the output for three cycles after the first block
    n_out = 0; n_acc = 0; fill_all(0);
    in_valid = 0; out_ready = 1;
    start = 1; step(); start = 0;
    in_valid = 1;
    guard = 0;
    while (!m_ov && guard < 50) begin step(); guard++; end
    check("bp_first_out", out_valid, 1);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_in_ready", in_ready, 0);
      check("bp_sat_en", sat_en, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_blk_idx", blk_idx, 0);
    end
    out_ready = 1;
    guard = 0;
    while (!m_done && guard < 200) begin step(); guard++; end
    in_valid = 0;
    if (!m_done) check("bp_timeout", 0, 1);
    step();
    check("bp_total_out", n_out, BLKS);
    check("bp_clip_cnt", clip_cnt, 0);

    // Reset mid-frame after five accepted blocks
    n_acc = 0; fill_all(8191);
    in_valid = 0; out_ready = 1;
    start = 1; step(); start = 0;
    in_valid = 1;
    guard = 0;
    while (n_acc < 5 && guard < 50) begin step(); guard++; end
    check("mid_accepts", n_acc, 5);
    in_valid = 0;
    rst_n = 0;
    step();
    rst_n = 1;
    check("mid_busy", busy, 0);
    check("mid_out_valid", out_valid, 0);
    check("mid_blk_idx", blk_idx, 0);
    check("mid_done", done, 0);
    check("mid_clip_cnt", clip_cnt, 0);
    repeat (4) step();

    // Randomized frames with backpressure, stray start pulses and junk idle data
    for (int f = 0; f < 5; f++) run_frame(1, 0, 0, 0, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_sat_ctrl.md
Name: fft_sat_ctrl

Overview:
- Frame-level controller for the 16-lane, 4-array (R/Q, add/sub) saturation stage of the FFT datapath.
- Sequences one frame of BLKS_PER_FRAME blocks through the stage using valid/ready flow control.
- Drives the stage's enable and aligns output valid with the stage's 1-cycle register latency.
- Monitors the stage inputs and counts clipped lane samples per frame for status and scaling decisions.

Parameters:
- WIDTH, 14, stage input sample width (signed)
- DEPTH, 16, lanes per array
- SAT_MAX_VAL, 4095, upper clip threshold
- SAT_MIN_VAL, -4096, lower clip threshold
- BLKS_PER_FRAME, 32, blocks per frame
- CNT_WIDTH, 11, clip counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin frame (honoured in IDLE only)
- in_valid  in  1  upstream block valid
- in_ready  out  1  controller accepts block
- din_R_add, din_R_sub, din_Q_add, din_Q_sub  in  [DEPTH] x WIDTH signed  monitored stage inputs
- sat_en  out  1  saturation stage register update enable
- out_valid  out  1  stage output block valid
- out_ready  in  1  downstream accepts block
- blk_idx  out  $clog2(BLKS_PER_FRAME)  index of block currently at stage output
- frame_last  out  1  out_valid && blk_idx==BLKS_PER_FRAME-1
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, frame complete
- clip_cnt  out  CNT_WIDTH  clip count of last completed frame
- clip_any  out  1  clip_cnt != 0

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous, active-low, on rst_n.
- Reset (rst_n=0 at posedge): state IDLE; every output 0, including clip_cnt, clip_any, blk_idx, done. The clip accumulator and input block counter also clear.
- Reset mid-frame: same result; the partial frame is discarded and no done pulse is issued.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start. Clears accumulator and input block counter.
  - RUN -> DRAIN on the accept of block BLKS_PER_FRAME-1.
  - DRAIN -> DONE on out_valid && out_ready while blk_idx==BLKS_PER_FRAME-1.
  - DONE -> IDLE after 1 cycle. done=1 in DONE; clip_cnt loads the accumulator at entry to DONE.
  - start outside IDLE is ignored.
- Handshake:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - accept = in_valid && in_ready.
  - sat_en = accept (combinational). The stage register updates only when sat_en=1, so it holds under backpressure.
- Output valid and index:
  - out_valid is set the cycle after accept. It clears on out_ready && !accept and holds otherwise.
  - blk_idx takes the accepted block's index on the same edge; latency is 1 cycle.
- Clip detection: a lane clips if din > SAT_MAX_VAL or din < SAT_MIN_VAL (signed compare).
  - Exactly SAT_MAX_VAL and exactly SAT_MIN_VAL are not clips.
  - Per-block clip count is the popcount over 4*DEPTH = 64 lanes (range 0..64).
- Accumulation:
  - The accumulator adds the per-block count on each accept.
  - It saturates at 2^CNT_WIDTH-1 (2047) and never wraps.
  - Inputs are sampled only on accept; din values in non-accept cycles are ignored.
- Simultaneous out_ready and accept: the output block is replaced, out_valid stays 1, no bubble. Full throughput is 1 block/cycle.
- Counter wrap: the input block counter resets to 0 after block BLKS_PER_FRAME-1.

Decomposition:
- Package fft_sat_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - lane count constant NUM_LANES = 4*DEPTH
  - default SAT_MAX_VAL / SAT_MIN_VAL constants
- Sub-module sat_clip_counter: combinational 64-lane range compare plus popcount, output 7 bits. The controller owns the FSM, handshake and accumulator.

Test Plan:
- Reset mid-frame: start, accept 5 blocks, hold rst_n=0 for 1 cycle -> next cycle state IDLE, out_valid=0, busy=0, blk_idx=0, no done pulse.
- Streaming frame: start, in_valid=1 and out_ready=1 continuously, all din=0 -> 32 consecutive accepts, frame_last high on the 32nd output cycle, done pulse 1 cycle later, clip_cnt=0, clip_any=0.
- Backpressure: out_ready=0 for 3 cycles after first output -> in_ready=0 and sat_en=0 during the stall, out_valid held, blk_idx stays 0, no block lost; total outputs = 32.
- Threshold boundary: block 0 lanes set to 4095, -4096, 4096, -4097 (one each) plus the rest 0 -> clip_cnt=2 at frame end.
- Counter saturation: all 64 lanes = 8191 for all 32 blocks (2048 clips) -> clip_cnt=2047, clip_any=1.
- start while busy, plus non-accept din: assert start during RUN and drive din=8191 while in_valid=0 -> no restart, blk_idx sequence unaffected, clip count unaffected.
